// File: rtl/joy_db9_pkg.sv
// Shared constants, types and pad-type decode for the multi-port DB9 / MD pad poller.
package joy_db9_pkg;

  // joystick word bit positions (active-high)
  localparam int unsigned BTN_R     = 0;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_D     = 2;
  localparam int unsigned BTN_U     = 3;
  localparam int unsigned BTN_B     = 4;
  localparam int unsigned BTN_C     = 5;
  localparam int unsigned BTN_A     = 6;
  localparam int unsigned BTN_START = 7;
  localparam int unsigned BTN_MODE  = 8;
  localparam int unsigned BTN_X     = 9;
  localparam int unsigned BTN_Y     = 10;
  localparam int unsigned BTN_Z     = 11;

  // joy_in line positions
  localparam int unsigned IN_U  = 0;
  localparam int unsigned IN_D  = 1;
  localparam int unsigned IN_L  = 2;
  localparam int unsigned IN_R  = 3;
  localparam int unsigned IN_BA = 4;
  localparam int unsigned IN_CS = 5;

  localparam int unsigned NUM_STEPS = 8;

  typedef enum logic [1:0] {
    PAD_NONE  = 2'b00,
    PAD_ATARI = 2'b01,
    PAD_MD3   = 2'b10,
    PAD_MD6   = 2'b11
  } pad_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PORT,
    ST_STEP,
    ST_COMMIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    pad_type_t   kind;
    logic [11:0] btn;
  } pad_result_t;

  // s2 holds only lines L,R,B/A,C/Start of step 2 (as [0]..[3]); s6/s7 hold U,D,L,R.
  function automatic pad_result_t decode_pad(input logic [5:0] s1, input logic [3:0] s2,
                                             input logic [3:0] s6, input logic [3:0] s7);
    pad_result_t r;
    r.kind           = PAD_NONE;
    r.btn            = '0;
    r.btn[BTN_R]     = s1[IN_R];
    r.btn[BTN_L]     = s1[IN_L];
    r.btn[BTN_D]     = s1[IN_D];
    r.btn[BTN_U]     = s1[IN_U];
    r.btn[BTN_B]     = s1[IN_BA];
    r.btn[BTN_C]     = s1[IN_CS];
    if (s2[0] & s2[1]) begin
      r.btn[BTN_A]     = s2[2];
      r.btn[BTN_START] = s2[3];
      if (&s6) begin
        r.kind          = PAD_MD6;
        r.btn[BTN_Z]    = s7[IN_U];
        r.btn[BTN_Y]    = s7[IN_D];
        r.btn[BTN_X]    = s7[IN_L];
        r.btn[BTN_MODE] = s7[IN_R];
      end else begin
        r.kind = PAD_MD3;
      end
    end else if (s1 != '0) begin
      r.kind = PAD_ATARI;
    end
    return r;
  endfunction

endpackage

// File: rtl/joy_db9_sync.sv
// Two-flop synchronizer for the six active-low pad lines; output is active-high.
module joy_db9_sync (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [5:0] joy_in,
  output logic [5:0] joy
);

  logic [5:0] meta;
  logic [5:0] stable;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta   <= '1;
      stable <= '1;
    end else begin
      meta   <= joy_in;
      stable <= meta;
    end
  end

  always_comb joy = ~stable;

endmodule

// File: rtl/joy_db9_mdpoll.sv
// Time-multiplexed DB9 / Mega Drive pad poller: scans NUM_PORTS pads through the
// 8-step select sequence and commits decoded button words per port.
module joy_db9_mdpoll
  import joy_db9_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned CLK_HZ        = 48_000_000,
  parameter int unsigned POLL_HZ       = 1000,
  parameter int unsigned SETTLE_CYCLES = 480
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [5:0]              joy_in,
  output logic                    joy_mdsel,
  output logic [NUM_PORTS-1:0]    joy_port,
  output logic [12*NUM_PORTS-1:0] joystick,
  output logic [2*NUM_PORTS-1:0]  pad_type,
  output logic                    scan_done
);

  localparam int unsigned POLL_DIV = CLK_HZ / POLL_HZ;
  localparam int unsigned DIV_W    = $clog2(POLL_DIV);
  localparam int unsigned SET_W    = $clog2(SETTLE_CYCLES);

  if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_ports
    $error("joy_db9_mdpoll: NUM_PORTS must be 1..4");
  end
  if (SETTLE_CYCLES < 4) begin : g_bad_settle
    $error("joy_db9_mdpoll: SETTLE_CYCLES must be >= 4");
  end
  if (NUM_PORTS * 9 * SETTLE_CYCLES >= POLL_DIV) begin : g_bad_rate
    $error("joy_db9_mdpoll: full scan does not fit in one poll period");
  end

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [1:0] idx);
    logic [NUM_PORTS-1:0] v;
    for (int unsigned i = 0; i < NUM_PORTS; i++) v[i] = (idx == 2'(i));
    return v;
  endfunction

  logic [5:0] joy_sync;

  joy_db9_sync u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .joy_in  (joy_in),
    .joy     (joy_sync)
  );

  logic [DIV_W-1:0] div;
  logic             tick;

  always_comb tick = (div == DIV_W'(POLL_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || tick) div <= '0;
    else               div <= div + DIV_W'(1);
  end

  state_t               state, state_n;
  logic [1:0]           pidx, pidx_n;
  logic [3:0]           step, step_n;
  logic [SET_W-1:0]     cnt, cnt_n;
  logic                 last, sample, commit;
  logic                 mdsel_n, done_n;
  logic [NUM_PORTS-1:0] port_n;

  always_comb last = (cnt == SET_W'(SETTLE_CYCLES - 1));

  always_comb begin
    state_n = state;
    pidx_n  = pidx;
    step_n  = step;
    cnt_n   = cnt;
    sample  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Ticks arriving outside IDLE are dropped rather than queued.
        if (tick) begin
          state_n = ST_PORT;
          pidx_n  = '0;
          cnt_n   = '0;
        end
      end
      ST_PORT: begin
        if (last) begin
          state_n = ST_STEP;
          step_n  = 4'd1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + SET_W'(1);
        end
      end
      ST_STEP: begin
        if (last) begin
          sample = 1'b1;
          cnt_n  = '0;
          if (step == 4'(NUM_STEPS)) state_n = ST_COMMIT;
          else                       step_n  = step + 4'd1;
        end else begin
          cnt_n = cnt + SET_W'(1);
        end
      end
      ST_COMMIT: begin
        commit = 1'b1;
        cnt_n  = '0;
        if (pidx == 2'(NUM_PORTS - 1)) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_PORT;
          pidx_n  = pidx + 2'd1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Pin outputs are registered from next-state so they switch with the state.
    mdsel_n = (state_n == ST_STEP) ? step_n[0] : 1'b1;
    port_n  = (state_n inside {ST_PORT, ST_STEP, ST_COMMIT}) ? onehot(pidx_n) : onehot(2'd0);
    done_n  = (state_n == ST_DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      pidx      <= '0;
      step      <= '0;
      cnt       <= '0;
      joy_mdsel <= 1'b1;
      joy_port  <= onehot(2'd0);
      scan_done <= 1'b0;
    end else begin
      state     <= state_n;
      pidx      <= pidx_n;
      step      <= step_n;
      cnt       <= cnt_n;
      joy_mdsel <= mdsel_n;
      joy_port  <= port_n;
      scan_done <= done_n;
    end
  end

  // Only the steps the decode looks at are kept.
  logic [5:0] cap1;
  logic [3:0] cap2, cap6, cap7;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cap1 <= '0;
      cap2 <= '0;
      cap6 <= '0;
      cap7 <= '0;
    end else if (sample) begin
      unique case (step)
        4'd1:    cap1 <= joy_sync;
        4'd2:    cap2 <= joy_sync[5:2];
        4'd6:    cap6 <= joy_sync[3:0];
        4'd7:    cap7 <= joy_sync[3:0];
        default: ;
      endcase
    end
  end

  pad_result_t dec;
  always_comb dec = decode_pad(cap1, cap2, cap6, cap7);

  logic [11:0] joy_q  [NUM_PORTS];
  pad_type_t   type_q [NUM_PORTS];

  always_ff @(posedge clk_sys) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (reset) begin
        joy_q[i]  <= '0;
        type_q[i] <= PAD_NONE;
      end else if (commit && pidx == 2'(i)) begin
        joy_q[i]  <= dec.btn;
        type_q[i] <= dec.kind;
      end
    end
  end

  always_comb begin
    joystick = '0;
    pad_type = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      joystick[12*i +: 12] = joy_q[i];
      pad_type[2*i +: 2]   = type_q[i];
    end
  end

endmodule

// File: tb/tb_joy_db9_mdpoll.sv
// Self-checking bench: pad models on three ports, cycle-level timing model of the scan.
module tb_joy_db9_mdpoll;

  localparam int unsigned P     = 3;
  localparam int unsigned S     = 8;
  localparam int unsigned CLKHZ = 3000;
  localparam int unsigned PHZ   = 10;
  localparam int unsigned D     = CLKHZ / PHZ;
  localparam int unsigned PS    = 9 * S + 1;
  localparam int unsigned SCAN  = P * PS;
  localparam int unsigned TMO   = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       joy_in;
  logic             joy_mdsel;
  logic [P-1:0]     joy_port;
  logic [12*P-1:0]  joystick;
  logic [2*P-1:0]   pad_type;
  logic             scan_done;

  joy_db9_mdpoll #(
    .NUM_PORTS     (P),
    .CLK_HZ        (CLKHZ),
    .POLL_HZ       (PHZ),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk_sys   (clk),
    .reset     (reset),
    .joy_in    (joy_in),
    .joy_mdsel (joy_mdsel),
    .joy_port  (joy_port),
    .joystick  (joystick),
    .pad_type  (pad_type),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  // pad kinds: 0 none, 1 Atari, 2 MD 3-button, 3 MD 6-button; btn in joystick-word layout
  int          kind [P];
  logic [11:0] btn  [P];

  int compared   = 0;
  int mismatched = 0;

  int unsigned n = 0;
  bit          model_ok = 1'b0;
  logic [11:0] exp_w [P];
  logic [1:0]  exp_t [P];

  int   falls = 0;
  int   hi_run = 0;
  logic prev_sel = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [5:0] pad_lines(input int k, input logic [11:0] b,
                                           input logic sel, input int f);
    logic [5:0] h;
    h = '0;
    case (k)
      1: h = {b[5], b[4], b[0], b[1], b[2], b[3]};
      2: h = sel ? {b[5], b[4], b[0], b[1], b[2], b[3]}
                 : {b[7], b[6], 1'b1, 1'b1, b[2], b[3]};
      3: begin
        if (sel) h = (f == 3) ? {b[5], b[4], b[8], b[9], b[10], b[11]}
                              : {b[5], b[4], b[0], b[1], b[2], b[3]};
        else     h = (f == 3) ? {b[7], b[6], 4'b1111}
                   : (f >= 4) ? {b[7], b[6], 4'b0000}
                              : {b[7], b[6], 2'b11, b[2], b[3]};
      end
      default: h = '0;
    endcase
    return ~h;
  endfunction

  // What a correct poller must report for a pad of this kind holding these buttons.
  function automatic logic [13:0] expect_pad(input int k, input logic [11:0] b);
    logic [11:0] w;
    case (k)
      1: begin
        w = b & 12'h03F;
        return {(w == 12'h000) ? 2'b00 : 2'b01, w};
      end
      2:       return {2'b10, b & 12'h0FF};
      3:       return {2'b11, b};
      default: return 14'h0;
    endcase
  endfunction

  always_comb begin
    joy_in = '1;
    for (int p = 0; p < P; p++)
      if (joy_port[p] === 1'b1) joy_in = pad_lines(kind[p], btn[p], joy_mdsel, falls);
  end

  // 6-button pad step counter: counts select falls, cleared after a long high period.
  always @(negedge clk) begin
    if (joy_mdsel === 1'b0) begin
      if (prev_sel) falls <= (falls < 7) ? falls + 1 : falls;
      hi_run   <= 0;
      prev_sel <= 1'b0;
    end else begin
      hi_run <= hi_run + 1;
      if (hi_run + 1 >= TMO) falls <= 0;
      prev_sel <= 1'b1;
    end
  end

  // Timing model: n counts clock edges since reset release; scans start every D cycles.
  always @(posedge clk) begin
    if (reset) begin
      n        <= 0;
      model_ok <= 1'b1;
      for (int p = 0; p < P; p++) begin
        exp_w[p] <= '0;
        exp_t[p] <= '0;
      end
    end else begin
      n <= n + 1;
      for (int p = 0; p < P; p++)
        if (n + 1 >= D && (n + 1) % D == (p + 1) * PS)
          {exp_t[p], exp_w[p]} <= expect_pad(kind[p], btn[p]);
    end
  end

  always @(negedge clk) begin
    int unsigned t, pi, u, k;
    logic         esel, edone;
    logic [P-1:0] eport;
    if (model_ok) begin
      esel  = 1'b1;
      edone = 1'b0;
      eport = P'(1);
      if (n >= D) begin
        t = n % D;
        if (t < SCAN) begin
          pi    = t / PS;
          u     = t % PS;
          eport = P'(1) << pi;
          if (u >= S && u < 9 * S) begin
            k    = (u - S) / S + 1;
            esel = (k % 2) == 1;
          end
        end else if (t == SCAN) begin
          edone = 1'b1;
        end
      end
      chk("mdsel", 64'(joy_mdsel), 64'(esel));
      chk("joy_port", 64'(joy_port), 64'(eport));
      chk("scan_done", 64'(scan_done), 64'(edone));
      for (int p = 0; p < P; p++) begin
        chk("joystick", 64'(joystick[12*p +: 12]), 64'(exp_w[p]));
        chk("pad_type", 64'(pad_type[2*p +: 2]), 64'(exp_t[p]));
      end
    end
  end

  task automatic wait_done();
    int c;
    c = 0;
    @(negedge clk);
    while (scan_done !== 1'b1 && c < 2 * D) begin
      @(negedge clk);
      c++;
    end
    chk("scan_done_wait", 64'(scan_done), 64'd1);
  endtask

  task automatic check_port(input int p, input logic [11:0] w, input logic [1:0] ty);
    chk($sformatf("lit_joy_p%0d", p), 64'(joystick[12*p +: 12]), 64'(w));
    chk($sformatf("lit_type_p%0d", p), 64'(pad_type[2*p +: 2]), 64'(ty));
  endtask

  task automatic check_reset_vals();
    chk("rst_joystick", 64'(joystick), 64'd0);
    chk("rst_pad_type", 64'(pad_type), 64'd0);
    chk("rst_mdsel", 64'(joy_mdsel), 64'd1);
    chk("rst_port", 64'(joy_port), 64'd1);
    chk("rst_done", 64'(scan_done), 64'd0);
  endtask

  task automatic release_and_time();
    int c;
    reset = 1'b0;
    c = 0;
    while (scan_done !== 1'b1 && c < 2 * D) begin
      @(negedge clk);
      c++;
    end
    chk("first_scan_latency", 64'(c), 64'(D + SCAN));
  endtask

  initial begin
    for (int p = 0; p < P; p++) begin
      kind[p] = 0;
      btn[p]  = '0;
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals();

    kind[0] = 3; btn[0] = 12'h880;
    kind[1] = 2; btn[1] = 12'h041;
    kind[2] = 0; btn[2] = 12'h000;
    release_and_time();
    check_port(0, 12'h880, 2'b11);
    check_port(1, 12'h041, 2'b10);
    check_port(2, 12'h000, 2'b00);

    kind[2] = 1; btn[2] = 12'h018;
    wait_done();
    check_port(2, 12'h018, 2'b01);
    check_port(0, 12'h880, 2'b11);

    btn[0] = 12'h308; btn[1] = 12'h0B0; btn[2] = 12'h0C4;
    wait_done();
    check_port(0, 12'h308, 2'b11);
    check_port(1, 12'h0B0, 2'b10);
    check_port(2, 12'h004, 2'b01);

    btn[0] = 12'h555; btn[1] = 12'hF41; btn[2] = 12'h000;
    wait_done();
    check_port(0, 12'h555, 2'b11);
    check_port(1, 12'h041, 2'b10);
    check_port(2, 12'h000, 2'b00);

    // abort in step 5 of port 1
    begin
      int c;
      c = 0;
      while (!(n >= D && n % D == PS + S + 4 * S + 3) && c < 2 * D) begin
        @(negedge clk);
        c++;
      end
      chk("reach_step5", 64'(n % D), 64'(PS + S + 4 * S + 3));
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    release_and_time();
    check_port(0, 12'h555, 2'b11);
    check_port(1, 12'h041, 2'b10);
    check_port(2, 12'h000, 2'b00);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
